// File: rtl/dbg_arb_pkg.sv
// Shared types for the debug-memory arbiter: host identifiers and arbiter states.
package dbg_arb_pkg;

   typedef enum logic {
      HostInstr = 1'b0,
      HostData  = 1'b1
   } host_e;

   typedef enum logic {
      ArbIdle = 1'b0,
      ArbHold = 1'b1
   } arb_state_e;

endpackage

// File: rtl/arb_id_fifo.sv
// Response-ID FIFO: remembers which host owns each outstanding device transaction.
module arb_id_fifo
   import dbg_arb_pkg::*;
#(
   parameter  int unsigned Depth = 2,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  host_e           wdata_i,
   output host_e           rdata_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   host_e           mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok, pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/dbg_mem_arbiter.sv
// Shares the debug-memory slave port between instruction fetch and the bus data port,
// returning every response in order to the host that issued it.
//
// state   | meaning
// ArbIdle | selection made combinationally from current requests
// ArbHold | request presented but not yet granted; mux locked to sel_q
module dbg_mem_arbiter
   import dbg_arb_pkg::*;
#(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          FetchPriority  = 1'b0
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   if_req_i,
   input  logic [AddrWidth-1:0]   if_addr_i,
   output logic                   if_gnt_o,
   output logic                   if_rvalid_o,
   output logic [DataWidth-1:0]   if_rdata_o,
   input  logic                   d_req_i,
   input  logic                   d_we_i,
   input  logic [DataWidth/8-1:0] d_be_i,
   input  logic [AddrWidth-1:0]   d_addr_i,
   input  logic [DataWidth-1:0]   d_wdata_i,
   output logic                   d_gnt_o,
   output logic                   d_rvalid_o,
   output logic [DataWidth-1:0]   d_rdata_o,
   output logic                   dev_req_o,
   output logic                   dev_we_o,
   output logic [DataWidth/8-1:0] dev_be_o,
   output logic [AddrWidth-1:0]   dev_addr_o,
   output logic [DataWidth-1:0]   dev_wdata_o,
   input  logic                   dev_gnt_i,
   input  logic                   dev_rvalid_i,
   input  logic [DataWidth-1:0]   dev_rdata_i,
   output logic                   unexp_rsp_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   arb_state_e      state_q, state_d;
   host_e           sel_q, sel_d, sel_c;
   host_e           rr_last_q, rr_last_d;
   host_e           fifo_head;
   logic            blk_q;
   logic            unexp_q, unexp_d;
   logic            out_blk, req_sel, can_issue, hs, pop;
   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] fifo_cnt;

   // Outputs stay quiet during reset and for the first cycle after it.
   assign out_blk   = rst_i | blk_q;
   assign can_issue = ~fifo_full && (fifo_cnt < CntW'(MaxOutstanding));

   always_comb begin
      sel_c = HostInstr;
      if (state_q == ArbHold) begin
         sel_c = sel_q;
      end else if (if_req_i && d_req_i) begin
         if (FetchPriority) sel_c = HostInstr;
         else               sel_c = (rr_last_q == HostInstr) ? HostData : HostInstr;
      end else if (d_req_i) begin
         sel_c = HostData;
      end
   end

   assign req_sel   = (sel_c == HostInstr) ? if_req_i : d_req_i;
   assign dev_req_o = req_sel & can_issue & ~out_blk;
   assign hs        = dev_req_o & dev_gnt_i;
   assign if_gnt_o  = hs & (sel_c == HostInstr);
   assign d_gnt_o   = hs & (sel_c == HostData);

   always_comb begin
      dev_we_o    = 1'b0;
      dev_be_o    = '0;
      dev_addr_o  = '0;
      dev_wdata_o = '0;
      if (!out_blk) begin
         if (sel_c == HostInstr) begin
            dev_addr_o = if_addr_i;
            dev_be_o   = '1;
         end else begin
            dev_we_o    = d_we_i;
            dev_be_o    = d_be_i;
            dev_addr_o  = d_addr_i;
            dev_wdata_o = d_wdata_i;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      rr_last_d = rr_last_q;
      if (hs) rr_last_d = sel_c;
      case (state_q)
         ArbIdle: begin
            if (req_sel && !hs) begin
               state_d = ArbHold;
               sel_d   = sel_c;
            end
         end
         ArbHold: begin
            if (hs || !req_sel) state_d = ArbIdle;
         end
         default: state_d = ArbIdle;
      endcase
   end

   // Responses are routed combinationally from the FIFO head; no extra pipeline stage.
   assign pop         = dev_rvalid_i & ~fifo_empty;
   assign if_rvalid_o = pop & (fifo_head == HostInstr) & ~out_blk;
   assign d_rvalid_o  = pop & (fifo_head == HostData) & ~out_blk;
   assign if_rdata_o  = if_rvalid_o ? dev_rdata_i : '0;
   assign d_rdata_o   = d_rvalid_o ? dev_rdata_i : '0;

   assign unexp_d     = unexp_q | (dev_rvalid_i & fifo_empty);
   assign unexp_rsp_o = unexp_q & ~out_blk;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ArbIdle;
         sel_q     <= HostInstr;
         rr_last_q <= HostData;
         blk_q     <= 1'b1;
         unexp_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         rr_last_q <= rr_last_d;
         blk_q     <= 1'b0;
         unexp_q   <= unexp_d;
      end
   end

   arb_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (hs),
      .pop_i   (pop),
      .wdata_i (sel_c),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Bench for dbg_mem_arbiter: a round-robin and a fetch-priority instance driven side by side,
// every output compared each cycle against a queue-based model of the arbitration rules.
module tb_dbg_mem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst;

   logic          if_req    [2];
   logic [AW-1:0] if_addr   [2];
   logic          d_req     [2];
   logic          d_we      [2];
   logic [BW-1:0] d_be      [2];
   logic [AW-1:0] d_addr    [2];
   logic [DW-1:0] d_wdata   [2];
   logic          dev_gnt   [2];
   logic          dev_rvalid[2];
   logic [DW-1:0] dev_rdata [2];

   logic          o_if_gnt   [2];
   logic          o_if_rvalid[2];
   logic [DW-1:0] o_if_rdata [2];
   logic          o_d_gnt    [2];
   logic          o_d_rvalid [2];
   logic [DW-1:0] o_d_rdata  [2];
   logic          o_dev_req  [2];
   logic          o_dev_we   [2];
   logic [BW-1:0] o_dev_be   [2];
   logic [AW-1:0] o_dev_addr [2];
   logic [DW-1:0] o_dev_wdata[2];
   logic          o_unexp    [2];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: outstanding host IDs in issue order, locked host, last winner.
   int mq [2][$];
   int lock_m [2];
   int rr_m   [2];
   bit unexp_m[2];
   bit blk_m  [2];
   bit lg_if  [2];
   bit lg_d   [2];
   bit auto_rsp;

   always #5 clk = ~clk;

   dbg_mem_arbiter #(
      .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO), .FetchPriority(1'b0)
   ) u_rr (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_gnt_o(o_if_gnt[0]),
      .if_rvalid_o(o_if_rvalid[0]), .if_rdata_o(o_if_rdata[0]),
      .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_be_i(d_be[0]), .d_addr_i(d_addr[0]),
      .d_wdata_i(d_wdata[0]), .d_gnt_o(o_d_gnt[0]), .d_rvalid_o(o_d_rvalid[0]),
      .d_rdata_o(o_d_rdata[0]), .dev_req_o(o_dev_req[0]), .dev_we_o(o_dev_we[0]),
      .dev_be_o(o_dev_be[0]), .dev_addr_o(o_dev_addr[0]), .dev_wdata_o(o_dev_wdata[0]),
      .dev_gnt_i(dev_gnt[0]), .dev_rvalid_i(dev_rvalid[0]), .dev_rdata_i(dev_rdata[0]),
      .unexp_rsp_o(o_unexp[0])
   );

   dbg_mem_arbiter #(
      .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO), .FetchPriority(1'b1)
   ) u_fp (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_gnt_o(o_if_gnt[1]),
      .if_rvalid_o(o_if_rvalid[1]), .if_rdata_o(o_if_rdata[1]),
      .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_be_i(d_be[1]), .d_addr_i(d_addr[1]),
      .d_wdata_i(d_wdata[1]), .d_gnt_o(o_d_gnt[1]), .d_rvalid_o(o_d_rvalid[1]),
      .d_rdata_o(o_d_rdata[1]), .dev_req_o(o_dev_req[1]), .dev_we_o(o_dev_we[1]),
      .dev_be_o(o_dev_be[1]), .dev_addr_o(o_dev_addr[1]), .dev_wdata_o(o_dev_wdata[1]),
      .dev_gnt_i(dev_gnt[1]), .dev_rvalid_i(dev_rvalid[1]), .dev_rdata_i(dev_rdata[1]),
      .unexp_rsp_o(o_unexp[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_cycle(input int k);
      bit blocked, full, creq, fp, e_req, e_ig, e_dg, e_ir, e_dr, e_we;
      int ch;
      logic [31:0] e_rd, e_addr, e_wd;
      logic [3:0]  e_be;
      string s;
      s       = (k == 0) ? "rr" : "fp";
      fp      = (k == 1);
      blocked = rst || blk_m[k];
      full    = mq[k].size() >= MAXO;
      if (lock_m[k] >= 0)               ch = lock_m[k];
      else if (if_req[k] && d_req[k])   ch = fp ? 0 : 1 - rr_m[k];
      else                              ch = d_req[k] ? 1 : 0;
      creq  = (ch == 0) ? if_req[k] : d_req[k];
      e_req = !blocked && creq && !full;
      e_ig  = e_req && dev_gnt[k] && (ch == 0);
      e_dg  = e_req && dev_gnt[k] && (ch == 1);
      e_ir  = 1'b0;
      e_dr  = 1'b0;
      e_rd  = '0;
      if (!blocked && dev_rvalid[k] && mq[k].size() > 0) begin
         e_rd = dev_rdata[k];
         if (mq[k][0] == 0) e_ir = 1'b1;
         else               e_dr = 1'b1;
      end
      chk({s, ".dev_req"},   o_dev_req[k],   e_req);
      chk({s, ".if_gnt"},    o_if_gnt[k],    e_ig);
      chk({s, ".d_gnt"},     o_d_gnt[k],     e_dg);
      chk({s, ".if_rvalid"}, o_if_rvalid[k], e_ir);
      chk({s, ".d_rvalid"},  o_d_rvalid[k],  e_dr);
      chk({s, ".if_rdata"},  o_if_rdata[k],  e_ir ? e_rd : 32'h0);
      chk({s, ".d_rdata"},   o_d_rdata[k],   e_dr ? e_rd : 32'h0);
      chk({s, ".unexp"},     o_unexp[k],     !blocked && unexp_m[k]);
      if (blocked) begin
         chk({s, ".blk_addr"},  o_dev_addr[k],  32'h0);
         chk({s, ".blk_we"},    o_dev_we[k],    32'h0);
         chk({s, ".blk_be"},    o_dev_be[k],    32'h0);
         chk({s, ".blk_wdata"}, o_dev_wdata[k], 32'h0);
      end else if (e_req) begin
         if (ch == 0) begin
            e_addr = if_addr[k]; e_we = 1'b0;    e_be = 4'hF;    e_wd = '0;
         end else begin
            e_addr = d_addr[k];  e_we = d_we[k]; e_be = d_be[k]; e_wd = d_wdata[k];
         end
         chk({s, ".dev_addr"},  o_dev_addr[k],  e_addr);
         chk({s, ".dev_we"},    o_dev_we[k],    e_we);
         chk({s, ".dev_be"},    o_dev_be[k],    e_be);
         chk({s, ".dev_wdata"}, o_dev_wdata[k], e_wd);
      end
      if (rst) begin
         mq[k].delete();
         lock_m[k]  = -1;
         rr_m[k]    = 1;
         unexp_m[k] = 1'b0;
         blk_m[k]   = 1'b1;
      end else begin
         if (dev_rvalid[k]) begin
            if (mq[k].size() > 0) void'(mq[k].pop_front());
            else                  unexp_m[k] = 1'b1;
         end
         if (e_ig || e_dg) begin
            mq[k].push_back(ch);
            rr_m[k] = ch;
         end
         lock_m[k] = (creq && !(e_ig || e_dg)) ? ch : -1;
         blk_m[k]  = 1'b0;
      end
      lg_if[k] = e_ig;
      lg_d[k]  = e_dg;
   endtask

   task automatic eval();
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_cycle(k);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      if (auto_rsp) begin
         for (int k = 0; k < 2; k++) begin
            dev_rvalid[k] = lg_if[k] | lg_d[k];
            dev_rdata[k]  = $urandom;
         end
      end
   endtask

   task automatic step();
      eval();
      adv();
   endtask

   task automatic set_if(input bit req, input logic [31:0] addr);
      for (int k = 0; k < 2; k++) begin
         if_req[k]  = req;
         if_addr[k] = addr;
      end
   endtask

   task automatic set_d(input bit req, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd);
      for (int k = 0; k < 2; k++) begin
         d_req[k] = req; d_we[k] = we; d_be[k] = be; d_addr[k] = addr; d_wdata[k] = wd;
      end
   endtask

   task automatic set_gnt(input bit g);
      for (int k = 0; k < 2; k++) dev_gnt[k] = g;
   endtask

   task automatic set_rsp(input bit v, input logic [31:0] d);
      for (int k = 0; k < 2; k++) begin
         dev_rvalid[k] = v;
         dev_rdata[k]  = d;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      rst      = 1'b1;
      auto_rsp = 1'b0;
      for (int k = 0; k < 2; k++) begin
         lock_m[k] = -1; rr_m[k] = 1; unexp_m[k] = 1'b0; blk_m[k] = 1'b1;
         lg_if[k] = 1'b0; lg_d[k] = 1'b0;
      end
      set_if(1'b0, '0);
      set_d(1'b0, 1'b0, '0, '0, '0);
      set_gnt(1'b0);
      set_rsp(1'b0, '0);
      adv();
      do_reset();

      // single fetch, response next cycle
      set_if(1'b1, 32'h1A11_0800);
      set_gnt(1'b1);
      eval();
      chk("t1.if_gnt", o_if_gnt[0], 32'h1);
      chk("t1.dev_addr", o_dev_addr[0], 32'h1A11_0800);
      adv();
      set_if(1'b0, '0);
      set_gnt(1'b0);
      set_rsp(1'b1, 32'hDEAD_BEEF);
      eval();
      chk("t1.if_rvalid", o_if_rvalid[0], 32'h1);
      chk("t1.if_rdata", o_if_rdata[0], 32'hDEAD_BEEF);
      chk("t1.d_rvalid", o_d_rvalid[0], 32'h0);
      adv();
      set_rsp(1'b0, '0);
      step();

      // both hosts requesting: alternation vs fetch priority
      do_reset();
      auto_rsp = 1'b1;
      set_if(1'b1, 32'h1A11_0810);
      set_d(1'b1, 1'b0, 4'hF, 32'h1A11_0400, '0);
      set_gnt(1'b1);
      for (int i = 0; i < 4; i++) begin
         eval();
         chk("t2.rr_if_gnt", o_if_gnt[0], (i % 2 == 0) ? 32'h1 : 32'h0);
         chk("t2.rr_d_gnt",  o_d_gnt[0],  (i % 2 == 1) ? 32'h1 : 32'h0);
         chk("t2.fp_if_gnt", o_if_gnt[1], 32'h1);
         adv();
      end
      set_if(1'b0, '0);
      set_d(1'b0, 1'b0, '0, '0, '0);
      step();
      step();

      // data write held off by the device while fetch appears
      set_gnt(1'b0);
      set_d(1'b1, 1'b1, 4'h3, 32'h1A11_0300, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) set_if(1'b1, 32'h1A11_0820);
         eval();
         chk("t3.dev_addr", o_dev_addr[0], 32'h1A11_0300);
         chk("t3.dev_be", o_dev_be[0], 32'h3);
         chk("t3.d_gnt", o_d_gnt[0], 32'h0);
         adv();
      end
      set_gnt(1'b1);
      eval();
      chk("t3.d_gnt4", o_d_gnt[0], 32'h1);
      chk("t3.if_gnt4", o_if_gnt[0], 32'h0);
      adv();
      set_d(1'b0, 1'b0, '0, '0, '0);
      eval();
      chk("t3.if_gnt5", o_if_gnt[0], 32'h1);
      adv();
      set_if(1'b0, '0);
      step();
      step();

      // outstanding limit: third grant only after a response has freed a slot
      auto_rsp = 1'b0;
      set_rsp(1'b0, '0);
      set_gnt(1'b1);
      set_if(1'b1, 32'h1A11_0830);
      step();
      step();
      eval();
      chk("t4.full_gnt", o_if_gnt[0], 32'h0);
      chk("t4.full_req", o_dev_req[0], 32'h0);
      adv();
      set_rsp(1'b1, 32'h0000_00A1);
      eval();
      chk("t4.pop_gnt", o_if_gnt[0], 32'h0);
      chk("t4.pop_rvalid", o_if_rvalid[0], 32'h1);
      adv();
      set_rsp(1'b0, '0);
      eval();
      chk("t4.third_gnt", o_if_gnt[0], 32'h1);
      adv();
      set_if(1'b0, '0);
      set_rsp(1'b1, 32'h0000_00A2);
      step();
      step();
      set_rsp(1'b0, '0);
      step();

      // response with nothing outstanding
      set_rsp(1'b1, 32'h0BAD_0BAD);
      eval();
      chk("t5.if_rvalid", o_if_rvalid[0], 32'h0);
      chk("t5.d_rvalid", o_d_rvalid[0], 32'h0);
      adv();
      set_rsp(1'b0, '0);
      eval();
      chk("t5.unexp_set", o_unexp[0], 32'h1);
      adv();
      eval();
      chk("t5.unexp_held", o_unexp[0], 32'h1);
      adv();
      do_reset();
      eval();
      chk("t5.unexp_clr", o_unexp[0], 32'h0);
      adv();

      // reset with two transactions outstanding, late responses afterwards
      set_if(1'b1, 32'h1A11_0840);
      step();
      step();
      set_if(1'b0, '0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_rsp(1'b1, 32'h0000_0C01);
      step();
      eval();
      chk("t6.if_rvalid", o_if_rvalid[0], 32'h0);
      chk("t6.d_rvalid", o_d_rvalid[0], 32'h0);
      adv();
      set_rsp(1'b0, '0);
      eval();
      chk("t6.unexp", o_unexp[0], 32'h1);
      adv();

      // randomized traffic with hold-until-grant hosts and a random device
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < 2; k++) begin
            if (!if_req[k] || lg_if[k]) begin
               if_req[k]  = ($urandom_range(0, 2) != 0);
               if_addr[k] = $urandom;
            end
            if (!d_req[k] || lg_d[k]) begin
               d_req[k]   = ($urandom_range(0, 2) != 0);
               d_we[k]    = $urandom_range(0, 1);
               d_be[k]    = $urandom_range(0, 15);
               d_addr[k]  = $urandom;
               d_wdata[k] = $urandom;
            end
            dev_gnt[k]    = ($urandom_range(0, 3) != 0);
            dev_rvalid[k] = (mq[k].size() > 0) && ($urandom_range(0, 1) == 1);
            dev_rdata[k]  = $urandom;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dbg_mem_arbiter.md
Name: dbg_mem_arbiter

Overview:
- Shares the single debug-module memory slave port between the core instruction-fetch port and the bus data device port (DbgDev).
- Gives each host a full req/gnt/rvalid handshake and arbitrates round-robin or with fixed fetch priority.
- Tracks outstanding transactions in an ID FIFO so every response returns, in order, to the host that issued it.
- Sits between the core fetch path, the bus, and dm_top. Fetches are steered here by address decode.

Parameters:
- AddrWidth, 32, address width of all ports.
- DataWidth, 32, data width of all ports.
- MaxOutstanding, 2, depth of the response-ID FIFO; must be >= 1.
- FetchPriority, 0: 0 = round-robin; 1 = instruction port always wins when both request.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- if_req_i  in  1  instruction fetch request.
- if_addr_i  in  AddrWidth  fetch address.
- if_gnt_o  out  1  fetch grant.
- if_rvalid_o  out  1  fetch response valid.
- if_rdata_o  out  DataWidth  fetch response data.
- d_req_i  in  1  data request from bus.
- d_we_i  in  1  data write enable.
- d_be_i  in  DataWidth/8  data byte enables.
- d_addr_i  in  AddrWidth  data address.
- d_wdata_i  in  DataWidth  write data.
- d_gnt_o  out  1  data grant.
- d_rvalid_o  out  1  data response valid (issued for reads and writes).
- d_rdata_o  out  DataWidth  data response data.
- dev_req_o  out  1  request to debug memory.
- dev_we_o  out  1  device write enable.
- dev_be_o  out  DataWidth/8  device byte enables.
- dev_addr_o  out  AddrWidth  device address.
- dev_wdata_o  out  DataWidth  device write data.
- dev_gnt_i  in  1  device accepts request.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  DataWidth  device response data.
- unexp_rsp_o  out  1  sticky flag: dev_rvalid_i arrived with the ID FIFO empty.

Behaviour:
- Reset (rst_i high on a clk_i edge):
  - FIFO is emptied; state returns to IDLE; rr_last = HostData, so the instruction port wins the first tie.
  - unexp_rsp_o = 0.
  - All outputs are 0 while reset is asserted and in the first cycle after it.
- Hosts follow OBI-style rules: once raised, req, addr, we, be and wdata are held until the host sees its gnt.
- State machine, registered sel_q:
  - IDLE: selection is made combinationally.
    - Only one host requesting: that host.
    - Both requesting: FetchPriority=1 gives the instruction port; otherwise the host != rr_last.
    - If dev_gnt_i=0, sel_q latches the selection and the state goes to HOLD.
  - HOLD: the mux is locked to sel_q and stays so until dev_gnt_i=1; a new request from the other host cannot preempt it. Then return to IDLE.
- Issue condition: fifo_count < MaxOutstanding.
  - When full, dev_req_o=0 and both gnt outputs are 0, even if a pop happens in the same cycle. There is no rvalid-to-gnt combinational path.
- dev_req_o = (selected host req) & ~full. The device fields are muxed from the selected host.
- For instruction requests: dev_we_o=0, dev_be_o = all ones, dev_wdata_o = 0.
- Handshake completes when dev_req_o & dev_gnt_i:
  - The selected host's gnt goes high in the same cycle (combinational from dev_gnt_i).
  - The host ID is pushed to the FIFO.
  - rr_last is updated to that host.
- Response path:
  - dev_rvalid_i pops the FIFO head and drives rvalid to that host in the same cycle, with rdata passed through.
  - The other host's rdata output is 0.
  - Push and pop in the same cycle are allowed; the count is unchanged.
- dev_rvalid_i with the FIFO empty: the response is dropped, no host rvalid is driven, and unexp_rsp_o sets and stays set until reset.
- Minimum latency: gnt in cycle N, device rvalid in cycle N+1, host rvalid in cycle N+1. There is no added pipeline stage.
- Back-to-back grants in consecutive cycles are supported until the FIFO is full.
- Reset with transactions outstanding: IDs are discarded. Late device responses after reset set unexp_rsp_o.

Decomposition:
- Package dbg_arb_pkg holds:
  - typedef enum logic host_e {HostInstr=0, HostData=1};
  - the arbiter state enum {ArbIdle, ArbHold}.
- Sub-module arb_id_fifo: synchronous FIFO of host_e entries.
  - Parameter Depth.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Synchronous active-high reset.

Test Plan:
- Single fetch to 0x1A110800, dev_gnt_i=1 immediately, rvalid next cycle with 0xDEADBEEF -> if_gnt_o same cycle, if_rvalid_o=1 and if_rdata_o=0xDEADBEEF one cycle later, d_rvalid_o stays 0.
- if_req_i and d_req_i both held high for 4 cycles, FetchPriority=0, dev_gnt_i=1 -> grants alternate I,D,I,D; responses route to matching ports in order. With FetchPriority=1 -> I granted each cycle the instruction port requests.
- Data write 0x1A110300, be=0x3, dev_gnt_i low for 3 cycles while if_req_i rises -> dev_addr_o stays 0x1A110300 throughout, d_gnt_o in cycle 4, fetch granted next.
- MaxOutstanding=2, device withholds rvalid -> two grants, then both gnt outputs 0. The cycle after the first rvalid, a third grant is issued.
- dev_rvalid_i pulsed with no outstanding request -> no host rvalid, unexp_rsp_o=1 and held; after rst_i=1 for one cycle -> 0.
- rst_i asserted with 2 outstanding, then 2 device responses -> no host rvalid, unexp_rsp_o=1.
